fifo_serial_tx: RTL

Downstream drain stage for the 16-bit FIFO. It pops one word at a time over the FIFO's ready-to-send / ready-to-receive output handshake and transmits it on a single asynchronous serial line: start bit, data LSB first, optional even parity, stop bit. It sits between the FIFO read port and the chip's serial pad and exposes busy and frame-done status to the controller.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/ser_baud_gen.sv | 28 ++
 rtl/fifo_serial_tx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions between the 16-bit FIFO and its serial drain stage:
// the common word width and the serializer state encoding.
package fifo_pkg;

    localparam int DATA_SIZE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } ser_state_t;

endpackage

// File: rtl/ser_baud_gen.sv
// Bit-period counter for the serializer: counts 0..CLKS_PER_BIT-1 and
// flags the last cycle of each bit period; restart holds it at zero.
module ser_baud_gen #(
    parameter int CLKS_PER_BIT = 16,
    localparam int CW = $clog2(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    output logic [CW-1:0] count,
    output logic          bit_tick
);

    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_tick = !restart && (count == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains the FIFO one word at a time and sends it on an async serial line:
// start bit, data LSB first, optional even parity, stop bit.
module fifo_serial_tx #(
    parameter int DATA_SIZE    = fifo_pkg::DATA_SIZE,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] ser_inp_data,
    input  logic                 ser_inp_rts,
    output logic                 ser_inp_rtr,
    output logic                 ser_txd,
    output logic                 ser_busy,
    output logic                 ser_frame_done
);

    import fifo_pkg::*;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_SIZE);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_SIZE - 1);
    localparam logic [CW-1:0] DONE_CNT  = CW'(CLKS_PER_BIT - 2);

    ser_state_t           state;
    ser_state_t           next_state;
    logic [DATA_SIZE-1:0] shift_q;
    logic [IW-1:0]        bit_idx;
    logic                 parity_q;
    logic                 txd_next;
    logic                 restart;
    logic                 bit_tick;
    logic [CW-1:0]        baud_cnt;

    // The bit counter is held at zero outside a frame so START begins on count 0.
    assign restart = (state == IDLE) || (state == POP) || (state == LOAD);

    ser_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .count    (baud_cnt),
        .bit_tick (bit_tick)
    );

    // Pop request comes straight from the state register: one word in flight.
    assign ser_inp_rtr = (state == POP);

    always_comb begin
        next_state = state;
        txd_next   = 1'b1;
        unique case (state)
            IDLE: begin
                if (ser_inp_rts) next_state = POP;
            end
            POP: begin
                next_state = ser_inp_rts ? LOAD : IDLE;
            end
            LOAD: begin
                next_state = START;
                txd_next   = 1'b0;
            end
            START: begin
                txd_next = 1'b0;
                if (bit_tick) begin
                    next_state = DATA;
                    txd_next   = shift_q[0];
                end
            end
            DATA: begin
                txd_next = shift_q[0];
                if (bit_tick) begin
                    if (bit_idx == LAST_IDX) begin
                        if (PARITY_EN != 0) begin
                            next_state = PARITY;
                            txd_next   = parity_q;
                        end else begin
                            next_state = STOP;
                            txd_next   = 1'b1;
                        end
                    end else begin
                        txd_next = shift_q[1];
                    end
                end
            end
            PARITY: begin
                txd_next = parity_q;
                if (bit_tick) begin
                    next_state = STOP;
                    txd_next   = 1'b1;
                end
            end
            STOP: begin
                if (bit_tick) next_state = ser_inp_rts ? POP : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            shift_q        <= '0;
            bit_idx        <= '0;
            parity_q       <= 1'b0;
            ser_txd        <= 1'b1;
            ser_busy       <= 1'b0;
            ser_frame_done <= 1'b0;
        end else begin
            state    <= next_state;
            ser_txd  <= txd_next;
            ser_busy <= (next_state != IDLE);
            // Registered one cycle early so the pulse lands on the last stop cycle.
            ser_frame_done <= (state == STOP) && (baud_cnt == DONE_CNT);
            if (state == LOAD) begin
                shift_q  <= ser_inp_data;
                parity_q <= ^ser_inp_data;
                bit_idx  <= '0;
            end else if ((state == DATA) && bit_tick && (bit_idx != LAST_IDX)) begin
                shift_q <= shift_q >> 1;
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule
